// File: rtl/baud_tick_gen_pkg.sv
// Shared UART clocking definitions: default divisor widths, the clamp floor for
// the integer divisor, and the reset-divisor calculation used by rx/tx blocks.
package baud_tick_gen_pkg;

  localparam int UART_INT_W   = 16;
  localparam int UART_FRAC_W  = 4;
  localparam int UART_DIV_W   = UART_INT_W + UART_FRAC_W;
  localparam int MIN_DIV_INT  = 2;

  // round(clk_rate * 2^frac_w / (baud_rate * oversample)) in Q(int).(frac_w)
  function automatic longint unsigned calc_def_div(
    input longint unsigned clk_rate,
    input longint unsigned baud_rate,
    input longint unsigned oversample,
    input int unsigned     frac_w
  );
    longint unsigned num;
    longint unsigned den;
    num = clk_rate << frac_w;
    den = baud_rate * oversample;
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/baud_tick_gen_frac_divider.sv
// Fractional cycle divider: counts div_int (+1 on fractional carry) cycles per
// os_tick and accumulates the fractional part at every tick.
module frac_divider #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              CLK_100MHZ,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick
);

  logic [INT_W:0]  cnt_q, cnt_d;
  logic [INT_W:0]  cnt_inc;
  logic [INT_W:0]  period;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W:0]   frac_sum;
  logic            carry_q, carry_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    carry_d  = carry_q;
    os_tick  = 1'b0;
    period   = {1'b0, div_int} + {{INT_W{1'b0}}, carry_q};
    cnt_inc  = cnt_q + 1'b1;
    frac_sum = {1'b0, frac_q} + {1'b0, div_frac};

    if (resync) begin
      cnt_d   = '0;
      frac_d  = '0;
      carry_d = 1'b0;
    end else if (enable) begin
      // >= rather than == keeps the counter bounded if a shorter divisor lands mid-period while disabled
      if (cnt_inc >= period) begin
        os_tick = !reset;
        cnt_d   = '0;
        frac_d  = frac_sum[FRAC_W-1:0];
        carry_d = frac_sum[FRAC_W];
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK_100MHZ) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      cnt_q   <= '0;
      frac_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frac_q  <= frac_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud/oversample tick generator with a fractional divisor that can be reloaded
// glitch-free at os_tick boundaries; bit_tick marks every OVERSAMPLE-th os_tick.
module baud_tick_gen
  import baud_tick_gen_pkg::*;
#(
  parameter int CLK_RATE     = 100000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int INT_W        = UART_INT_W,
  parameter int FRAC_W       = UART_FRAC_W
) (
  input  logic                    CLK_100MHZ,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    resync,
  input  logic [INT_W+FRAC_W-1:0] div_in,
  input  logic                    div_load,
  output logic                    div_ack,
  output logic [INT_W+FRAC_W-1:0] div_active,
  output logic                    os_tick,
  output logic                    bit_tick
);

  localparam int DIV_W = INT_W + FRAC_W;
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEF_DIV =
    DIV_W'(calc_def_div(CLK_RATE, DEFAULT_BAUD, OVERSAMPLE, FRAC_W));
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [DIV_W-1:0] pend_clamped;
  logic [INT_W-1:0] pend_int;
  logic             apply;

  frac_divider #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_frac_divider (
    .CLK_100MHZ (CLK_100MHZ),
    .reset      (reset),
    .enable     (enable),
    .resync     (resync),
    .div_int    (div_active_q[DIV_W-1:FRAC_W]),
    .div_frac   (div_active_q[FRAC_W-1:0]),
    .os_tick    (os_tick)
  );

  always_comb begin
    pend_int     = pend_div_q[DIV_W-1:FRAC_W];
    pend_clamped = pend_div_q;
    if (pend_int < INT_W'(MIN_DIV_INT)) begin
      pend_clamped = {INT_W'(MIN_DIV_INT), pend_div_q[FRAC_W-1:0]};
    end

    // The divisor only changes at a period boundary, or when no period is running
    apply = pend_valid_q && (os_tick || !enable || resync);

    div_active_d = apply ? pend_clamped : div_active_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q && !apply;
    if (div_load) begin
      pend_div_d   = div_in;
      pend_valid_d = 1'b1;
    end

    sub_d = sub_q;
    if (resync) begin
      sub_d = '0;
    end else if (os_tick) begin
      sub_d = sub_q + 1'b1;
    end
  end

  always_comb begin
    div_ack    = apply && !reset;
    bit_tick   = os_tick && (sub_q == SUB_LAST);
    div_active = div_active_q;
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      div_active_q <= DEF_DIV;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      sub_q        <= '0;
    end else begin
      div_active_q <= div_active_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      sub_q        <= sub_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters: divisor timing,
// fractional carries, reloads, resync, enable freeze, clamping and reset.
module tb_baud_tick_gen;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        resync;
  logic [19:0] div_in;
  logic        div_load;
  logic        div_ack;
  logic [19:0] div_active;
  logic        os_tick;
  logic        bit_tick;

  int checks   = 0;
  int failures = 0;

  logic os_s, bit_s, ack_s;

  baud_tick_gen dut (
    .CLK_100MHZ (clk),
    .reset      (reset),
    .enable     (enable),
    .resync     (resync),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .div_active (div_active),
    .os_tick    (os_tick),
    .bit_tick   (bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock cycle: outputs sampled mid-cycle, then return just after the next edge
  task automatic cyc();
    @(negedge clk);
    os_s  = os_tick;
    bit_s = bit_tick;
    ack_s = div_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_os(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!os_s && n < limit);
  endtask

  task automatic run_until_bit(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bit_s && n < limit);
  endtask

  initial begin
    int n;
    int seen;
    int p [6];
    int exp_p [6];

    exp_p = '{4, 4, 5, 4, 5, 4};

    // Reset with every other control asserted: reset must win
    reset    = 1'b1;
    enable   = 1'b1;
    resync   = 1'b1;
    div_load = 1'b1;
    div_in   = {16'd7, 4'd0};
    cyc();
    cyc();
    check("reset_os_tick", os_s, 0);
    check("reset_bit_tick", bit_s, 0);
    check("reset_div_ack", ack_s, 0);
    check("reset_div_active", div_active, 10417);

    // Default divisor 651 + 1/16: sixteen 651-cycle periods, then one of 652
    reset    = 1'b0;
    resync   = 1'b0;
    div_load = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      run_until_os(2000, n);
      check($sformatf("def_period_%0d", k), n, (k == 17) ? 652 : 651);
      check($sformatf("def_bit_%0d", k), bit_s, (k == 16) ? 1 : 0);
      check($sformatf("def_ack_%0d", k), ack_s, 0);
    end
    check("def_div_active", div_active, 10417);

    // Load 4.0 in the first cycle of a 651 period; applied at its os_tick
    div_load = 1'b1;
    div_in   = {16'd4, 4'd0};
    cyc();
    div_load = 1'b0;
    check("load4_no_early_ack", ack_s, 0);
    run_until_os(2000, n);
    check("load4_remaining", n, 650);
    check("load4_ack", ack_s, 1);
    check("load4_div_active", div_active, 64);
    run_until_os(100, n);
    check("load4_period_a", n, 4);
    check("load4_ack_once", ack_s, 0);
    run_until_os(100, n);
    check("load4_period_b", n, 4);
    run_until_bit(500, n);
    check("load4_first_bit", n, 48);
    run_until_bit(500, n);
    check("load4_bit_spacing", n, 64);

    // Resync in the cycle that would otherwise tick (mid-period, sub=2)
    run_until_os(100, n);
    run_until_os(100, n);
    cyc();
    cyc();
    cyc();
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    check("resync_suppress_os", os_s, 0);
    check("resync_suppress_bit", bit_s, 0);
    run_until_os(100, n);
    check("resync_first_os", n, 4);
    run_until_bit(500, n);
    check("resync_bit", n, 60);

    // Load 4.5: periods 4,4,5,4,5,4 from an aligned accumulator
    div_load = 1'b1;
    div_in   = {16'd4, 4'd8};
    cyc();
    div_load = 1'b0;
    run_until_os(100, n);
    check("load45_remaining", n, 3);
    check("load45_ack", ack_s, 1);
    check("load45_div_active", div_active, 72);
    for (int k = 0; k < 6; k++) begin
      run_until_os(100, p[k]);
      check($sformatf("load45_period_%0d", k), p[k], exp_p[k]);
    end
    check("load45_two_ticks", p[4] + p[5], 9);

    // Enable low for 100 cycles, two cycles into a 5-cycle period
    cyc();
    cyc();
    enable = 1'b0;
    seen   = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (os_s || bit_s) seen++;
    end
    check("disable_no_ticks", seen, 0);
    enable = 1'b1;
    run_until_os(100, n);
    check("disable_resume", n, 3);

    // Load int 1 while disabled: acked next cycle, clamped to 2
    enable   = 1'b0;
    div_load = 1'b1;
    div_in   = {16'd1, 4'd0};
    cyc();
    div_load = 1'b0;
    check("dis_load_no_ack_yet", ack_s, 0);
    cyc();
    check("dis_load_ack", ack_s, 1);
    check("clamp1_div_active", div_active, 32);
    enable = 1'b1;
    run_until_os(100, n);
    check("clamp1_period_a", n, 2);
    run_until_os(100, n);
    check("clamp1_period_b", n, 2);

    // Load int 0 while running
    div_load = 1'b1;
    div_in   = {16'd0, 4'd0};
    cyc();
    div_load = 1'b0;
    run_until_os(100, n);
    check("clamp0_remaining", n, 1);
    check("clamp0_ack", ack_s, 1);
    check("clamp0_div_active", div_active, 32);
    run_until_os(100, n);
    check("clamp0_period", n, 2);

    // Load 3.0 then load 2.0 in the applying cycle: 3.0 applies, 2.0 waits
    div_load = 1'b1;
    div_in   = {16'd3, 4'd0};
    cyc();
    div_in   = {16'd2, 4'd0};
    cyc();
    div_load = 1'b0;
    check("coinc_os", os_s, 1);
    check("coinc_ack_first", ack_s, 1);
    check("coinc_div_active_first", div_active, 48);
    run_until_os(100, n);
    check("coinc_period", n, 3);
    check("coinc_ack_second", ack_s, 1);
    check("coinc_div_active_second", div_active, 32);

    // Reset mid-period: next tick after the full default divisor
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midreset_div_active", div_active, 10417);
    run_until_os(2000, n);
    check("midreset_first_os", n, 651);
    check("midreset_ack", ack_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
